// File: rtl/add_serial_pkg.sv
// Shared definitions for the bit-serial adder and its request scheduler.
package add_serial_pkg;

   // Default adder width and ADD-phase length (one cycle per bit)
   localparam int unsigned ADD_SERIAL_W   = 8;
   localparam int unsigned ADD_SERIAL_LAT = 8;

   // Scheduler sequencing states
   typedef enum logic [2:0] {
      ST_ARB     = 3'd0,
      ST_START   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_RECOVER = 3'd4
   } sched_state_e;

   // Index width that never collapses to zero bits
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
   import add_serial_pkg::*;
#(
   parameter  int unsigned NREQ = 4,
   localparam int unsigned IDXW = clog2_min1(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDXW-1:0] ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDXW-1:0] idx_o,
   output logic            any_o
);

   // Scan requesters starting at ptr; the first hit wins
   always_comb begin
      int unsigned j;
      j     = 0;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         j = (32'(ptr_i) + k) % NREQ;
         if (!any_o && req_i[IDXW'(j)]) begin
            any_o            = 1'b1;
            idx_o            = IDXW'(j);
            gnt_o[IDXW'(j)]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/add_serial_sched.sv
// Round-robin scheduler sharing one bit-serial adder among NREQ requesters.
module add_serial_sched
   import add_serial_pkg::*;
#(
   parameter  int unsigned NREQ    = 4,
   parameter  int unsigned W       = ADD_SERIAL_W,
   parameter  int unsigned ADD_LAT = ADD_SERIAL_LAT,
   localparam int unsigned IDXW    = clog2_min1(NREQ),
   localparam int unsigned CNTW    = clog2_min1(ADD_LAT)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NREQ-1:0]   req_i,
   input  logic [NREQ*W-1:0] a_in_i,
   input  logic [NREQ*W-1:0] b_in_i,
   output logic [NREQ-1:0]   gnt_o,
   output logic [NREQ-1:0]   rsp_valid_o,
   output logic [W-1:0]      rsp_data_o,
   output logic              busy_o,
   output logic              add_en_o,
   output logic [W-1:0]      add_a_o,
   output logic [W-1:0]      add_b_o,
   input  logic [W-1:0]      add_out_i
);

   sched_state_e    state_q, state_d;
   logic [IDXW-1:0] ptr_q, ptr_d;
   logic [IDXW-1:0] owner_q, owner_d;
   logic [CNTW-1:0] wcnt_q, wcnt_d;
   logic [W-1:0]    a_hold_q, a_hold_d;
   logic [W-1:0]    b_hold_q, b_hold_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [W-1:0]    rsp_data_q, rsp_data_d;
   logic            busy_q, busy_d;
   logic            add_en_q, add_en_d;

   logic [NREQ-1:0] pick_gnt;
   logic [IDXW-1:0] pick_idx;
   logic            pick_any;

   rr_pick #(.NREQ(NREQ)) u_rr_pick (
      .req_i (req_i),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   // Next-state and registered-output logic for the load/add/capture sequence
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      wcnt_d      = wcnt_q;
      a_hold_d    = a_hold_q;
      b_hold_d    = b_hold_q;
      gnt_d       = '0;
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;

      unique case (state_q)
         ST_ARB: begin
            if (pick_any) begin
               a_hold_d = a_in_i[32'(pick_idx)*W +: W];
               b_hold_d = b_in_i[32'(pick_idx)*W +: W];
               owner_d  = pick_idx;
               gnt_d    = pick_gnt;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            ptr_d   = (owner_q == IDXW'(NREQ-1)) ? '0 : owner_q + IDXW'(1);
            wcnt_d  = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            wcnt_d = wcnt_q + CNTW'(1);
            if (wcnt_q == CNTW'(ADD_LAT-1)) begin
               state_d = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            rsp_data_d           = add_out_i;
            rsp_valid_d          = '0;
            rsp_valid_d[owner_q] = 1'b1;
            state_d              = ST_RECOVER;
         end
         ST_RECOVER: begin
            state_d = ST_ARB;
         end
         default: begin
            state_d = ST_ARB;
         end
      endcase

      // Enable and busy are registered so they line up with the state they describe
      busy_d   = (state_d != ST_ARB);
      add_en_d = (state_d == ST_START);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_ARB;
         ptr_q       <= '0;
         owner_q     <= '0;
         wcnt_q      <= '0;
         a_hold_q    <= '0;
         b_hold_q    <= '0;
         gnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         busy_q      <= 1'b0;
         add_en_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         wcnt_q      <= wcnt_d;
         a_hold_q    <= a_hold_d;
         b_hold_q    <= b_hold_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         busy_q      <= busy_d;
         add_en_q    <= add_en_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign busy_o      = busy_q;
   assign add_en_o    = add_en_q;
   assign add_a_o     = a_hold_q;
   assign add_b_o     = b_hold_q;

endmodule

// File: tb/tb_add_serial_sched.sv
// Randomized and directed bench for add_serial_sched against a transaction-level timeline model.
module tb_add_serial_sched;

   localparam int unsigned NREQ    = 4;
   localparam int unsigned W       = 8;
   localparam int unsigned ADD_LAT = 8;
   localparam int unsigned SLOTS   = 64;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*W-1:0] a_in = '0;
   logic [NREQ*W-1:0] b_in = '0;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   rsp_valid;
   logic [W-1:0]      rsp_data;
   logic              busy;
   logic              add_en;
   logic [W-1:0]      add_a;
   logic [W-1:0]      add_b;
   logic [W-1:0]      add_out;

   always #5 clk = ~clk;

   add_serial_sched #(.NREQ(NREQ), .W(W), .ADD_LAT(ADD_LAT)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_i       (req),
      .a_in_i      (a_in),
      .b_in_i      (b_in),
      .gnt_o       (gnt),
      .rsp_valid_o (rsp_valid),
      .rsp_data_o  (rsp_data),
      .busy_o      (busy),
      .add_en_o    (add_en),
      .add_a_o     (add_a),
      .add_b_o     (add_b),
      .add_out_i   (add_out)
   );

   // Behavioural adder: sum is presented only in the cycle ADD_LAT+1 after the en cycle
   int          adder_cnt = 1000;
   logic [W-1:0] adder_sum = '0;
   logic [W-1:0] junk      = 8'h01;
   always @(posedge clk) begin
      junk <= W'($urandom_range(1, 255));
      if (rst) adder_cnt <= 1000;
      else if (add_en) begin
         adder_cnt <= 0;
         adder_sum <= add_a + add_b;
      end else if (adder_cnt < 1000) adder_cnt <= adder_cnt + 1;
   end
   assign add_out = (adder_cnt == int'(ADD_LAT)) ? adder_sum : (adder_sum ^ junk);

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Timeline model state
   int              cyc = 0;
   int              arb_cyc = 0;
   int              ptr_m = 0;
   logic [NREQ-1:0] exp_gnt [SLOTS];
   logic [NREQ-1:0] exp_rsp [SLOTS];
   logic [W-1:0]    exp_sum [SLOTS];
   logic [W-1:0]    exp_data = '0;
   logic [NREQ-1:0] drop_mask = '1;
   logic [NREQ-1:0] just_granted = '0;

   task automatic clear_model();
      for (int s = 0; s < int'(SLOTS); s++) begin
         exp_gnt[s] = '0;
         exp_rsp[s] = '0;
         exp_sum[s] = '0;
      end
   endtask

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      a_in[i*W +: W] = a;
      b_in[i*W +: W] = b;
   endtask

   // Advance one clock: predict from current drives, then check the new cycle
   task automatic tick();
      int idx;
      int slot;
      if (rst) begin
         clear_model();
         ptr_m    = 0;
         exp_data = '0;
         arb_cyc  = cyc + 1;
      end else if (cyc == arb_cyc) begin
         if (req != '0) begin
            idx = -1;
            for (int k = 0; k < int'(NREQ); k++) begin
               if (idx < 0 && req[(ptr_m + k) % NREQ]) idx = (ptr_m + k) % NREQ;
            end
            exp_gnt[(cyc + 1) % SLOTS]  = NREQ'(1) << idx;
            exp_rsp[(cyc + 11) % SLOTS] = NREQ'(1) << idx;
            exp_sum[(cyc + 11) % SLOTS] = a_in[idx*W +: W] + b_in[idx*W +: W];
            ptr_m   = (idx + 1) % NREQ;
            arb_cyc = cyc + 12;
         end else begin
            arb_cyc = cyc + 1;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      slot = cyc % SLOTS;
      if (exp_rsp[slot] != '0) exp_data = exp_sum[slot];
      check_eq("gnt", 32'(gnt), 32'(exp_gnt[slot]));
      check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rsp[slot]));
      check_eq("rsp_data", 32'(rsp_data), 32'(exp_data));
      check_eq("busy", 32'(busy), 32'(cyc != arb_cyc));
      check_eq("add_en", 32'(add_en), 32'(exp_gnt[slot] != '0));
      exp_gnt[slot] = '0;
      exp_rsp[slot] = '0;
      just_granted  = gnt;
      for (int i = 0; i < int'(NREQ); i++) if (gnt[i] && drop_mask[i]) req[i] = 1'b0;
   endtask

   task automatic go_idle();
      while (cyc != arb_cyc) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   logic [NREQ-1:0] order [5];

   initial begin
      clear_model();
      order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
      order[3] = 4'b1000; order[4] = 4'b0001;

      // Reset state
      do_reset();
      check_eq("reset_add_a", 32'(add_a), 32'h0);
      check_eq("reset_add_b", 32'(add_b), 32'h0);

      // Single request
      set_op(0, 8'h35, 8'h4A);
      req = 4'b0001;
      tick();
      check_eq("single_gnt", 32'(gnt), 32'h1);
      for (int i = 0; i < 10; i++) tick();
      check_eq("single_valid", 32'(rsp_valid), 32'h1);
      check_eq("single_sum", 32'(rsp_data), 32'h7F);
      go_idle();

      // Wrap sum
      set_op(2, 8'hFF, 8'h02);
      req = 4'b0100;
      for (int i = 0; i < 11; i++) tick();
      check_eq("wrap_valid", 32'(rsp_valid), 32'h4);
      check_eq("wrap_sum", 32'(rsp_data), 32'h01);
      go_idle();

      // Contention with all requests held from reset
      do_reset();
      drop_mask = '0;
      for (int i = 0; i < int'(NREQ); i++) set_op(i, W'(8'h10 * (i + 1) + 3), W'(8'h21 + i));
      req = '1;
      for (int g = 0; g < 5; g++) begin
         tick();
         check_eq("contend_order", 32'(gnt), 32'(order[g]));
         for (int i = 0; i < 11; i++) tick();
      end
      req = '0;
      drop_mask = '1;
      go_idle();

      // Pointer fairness: after requester 3, pointer wraps to 0
      req = 4'b1000;
      set_op(3, 8'h11, 8'h22);
      tick();
      go_idle();
      set_op(0, 8'h01, 8'h02);
      set_op(3, 8'h03, 8'h04);
      req = 4'b1001;
      tick();
      check_eq("ptr_wrap_gnt", 32'(gnt), 32'h1);
      go_idle();
      go_idle();
      tick();
      go_idle();

      // Reset mid-WAIT drops the operation
      do_reset();
      set_op(1, 8'h40, 8'h40);
      req = 4'b0010;
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      tick();
      check_eq("rst_mid_add_a", 32'(add_a), 32'h0);
      check_eq("rst_mid_data", 32'(rsp_data), 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 14; i++) tick();
      set_op(1, 8'h12, 8'h34);
      req = 4'b0010;
      for (int i = 0; i < 11; i++) tick();
      check_eq("after_rst_sum", 32'(rsp_data), 32'h46);
      go_idle();

      // Request raised while busy is served at the next arbitration
      set_op(0, 8'h05, 8'h06);
      req = 4'b0001;
      for (int i = 0; i < 4; i++) tick();
      set_op(1, 8'h07, 8'h08);
      req[1] = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      check_eq("busy_req_gnt", 32'(gnt), 32'h2);
      go_idle();

      // Randomized traffic with skips, re-requests and occasional reset
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 399) == 0);
         drop_mask = NREQ'($urandom);
         for (int i = 0; i < int'(NREQ); i++) begin
            if (!req[i] && !just_granted[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  set_op(i, W'($urandom), W'($urandom));
                  req[i] = 1'b1;
               end
            end else if (req[i] && $urandom_range(0, 40) == 0) begin
               req[i] = 1'b0;
            end
         end
         tick();
      end
      rst = 1'b0;
      req = '0;
      tick();
      go_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/add_serial_sched.md
# add_serial_sched

Round-robin scheduler that shares one `add_serial` 8-bit bit-serial adder among `NREQ` requesters. It accepts an operand pair from one requester at a time and sequences the adder through load, add and done. It then returns the sum to the originating requester with a one-cycle response pulse. It sits between the client ports and the single `add_serial` instance in the arithmetic cluster.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `W`, 8: operand/result width; must equal the adder width.
- `ADD_LAT`, 8: adder ADD-phase length in cycles; equals W.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `req`  in  NREQ  per-requester request level; held until its `gnt` bit pulses.
- `a_in`  in  NREQ*W  operand A, requester i at bits [i*W +: W].
- `b_in`  in  NREQ*W  operand B, same packing.
- `gnt`  out  NREQ  one-hot, one-cycle pulse: operands of that requester captured.
- `rsp_valid`  out  NREQ  one-hot, one-cycle pulse: `rsp_data` is the sum for that requester.
- `rsp_data`  out  W  last captured sum; held until the next capture.
- `busy`  out  1  high in every state except ARB.
- `add_en`  out  1  drives adder `en`.
- `add_a`  out  W  drives adder `a`.
- `add_b`  out  W  drives adder `b`.
- `add_out`  in  W  adder `out`.

## Operation
- States: ARB, START, WAIT, CAPTURE, RECOVER. Reset state is ARB.
- ARB:
  - If any `req` bit is set, pick the first set bit at or after `ptr`, wrapping modulo NREQ.
  - Latch that requester's A and B into `a_hold`/`b_hold`, record `owner`, pulse `gnt[owner]` on the next cycle, and go to START.
  - With no request, stay in ARB.
- START:
  - `add_en`=1; `add_a`/`add_b` = held operands. The adder leaves IDLE and loads.
  - `ptr` <= owner+1 mod NREQ.
  - `wcnt` <= 0; go to WAIT.
- WAIT:
  - `add_en`=0; `wcnt` increments each cycle.
  - After ADD_LAT cycles (`wcnt`==ADD_LAT-1), go to CAPTURE.
- CAPTURE:
  - `rsp_data` <= `add_out`; `rsp_valid[owner]` pulses on the next cycle.
  - Go to RECOVER.
- RECOVER:
  - `add_en` stays 0 for one cycle so the adder returns from DONE to IDLE.
  - Go to ARB.
- `add_a`/`add_b` are driven from the hold registers in every state; `add_en` is high only in START.
- Requests arriving while busy are not lost. A held `req` is arbitrated at the next ARB.
- A requester whose `req` drops before grant is simply skipped.
- Sum is modulo 2^W; the carry-out is discarded.

## Timing
- Reset values:
  - Outputs: `gnt`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0, `add_en`=0, `add_a`=0, `add_b`=0.
  - Internal: `ptr`=0, `owner`=0, `wcnt`=0, hold registers 0.
- Cycle schedule, with cycle 0 = ARB edge that samples `req`:
  - cycle 1: `gnt` pulse, START, `add_en`=1.
  - cycles 2..9: WAIT.
  - cycle 10: CAPTURE.
  - cycle 11: `rsp_valid` pulse, RECOVER.
  - cycle 12: ARB.
- Grant-to-response is 10 cycles. Back-to-back throughput is one operation per 12 cycles.
- Requester may change `a_in`/`b_in` from the cycle after `gnt`.
- `rst` asserted in any state:
  - Next cycle is ARB with all reset values.
  - The in-flight operation is dropped and no `rsp_valid` is issued.
  - `add_serial` shares the same `rst`, so both return to IDLE together.
- Simultaneous `req` on all bits: grant order is ptr, ptr+1, … and each requester is served once before any repeats.
- `ptr` wraps from NREQ-1 to 0.

## Structure
- Shared package `add_serial_pkg`:
  - Scheduler state enum (ARB, START, WAIT, CAPTURE, RECOVER), 3-bit.
  - Default W and ADD_LAT constants, shared with `add_serial`.
- One natural sub-module: `rr_pick`.
  - Combinational round-robin priority picker.
  - Inputs: `req`, `ptr`. Outputs: one-hot grant and index.
  - Reused by other shared-resource schedulers.
- The scheduler does not instantiate `add_serial`. The top level wires the `add_*` ports to it.

## Test plan
- Single request:
  - Stimulus: reset, then `req`=0001 with A=0x35, B=0x4A.
  - Required: `gnt`=0001 at cycle 1; `add_en` high only at cycle 1; `rsp_valid`=0001 with `rsp_data`=0x7F at cycle 11.
- Wrap sum:
  - Stimulus: requester 2, A=0xFF, B=0x02.
  - Required: `rsp_data`=0x01, `rsp_valid`=0100.
- Contention:
  - Stimulus: all four `req` held from reset, with distinct operands.
  - Required: grants 0001, 0010, 0100, 1000, then 0001, spaced 12 cycles; each `rsp_valid` matches its requester's sum.
- Pointer fairness:
  - Stimulus: serve requester 3, then assert `req`=1001.
  - Required: requester 0 is granted first, because `ptr` wrapped to 0.
- Reset mid-WAIT:
  - Stimulus: assert `rst` at cycle 5 of an operation.
  - Required: no `rsp_valid`; all outputs 0 next cycle; a fresh request afterwards completes correctly.
- Request during busy:
  - Stimulus: requester 1 raises `req` at cycle 4 of requester 0's operation.
  - Required: requester 1 is granted at cycle 13 and is not lost.
